// File: rtl/exe_pkg.sv
// Shared definitions for the MyProc execute stage: op encodings, flag indices, FSM states.
package exe_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_LUI  = 5'd8;
  localparam logic [4:0] OP_LD   = 5'd9;
  localparam logic [4:0] OP_ST   = 5'd10;
  localparam logic [4:0] OP_BEQZ = 5'd11;
  localparam logic [4:0] OP_BNEZ = 5'd12;
  localparam logic [4:0] OP_BGTZ = 5'd13;
  localparam logic [4:0] OP_BLTZ = 5'd14;
  localparam logic [4:0] OP_BLEZ = 5'd15;
  localparam logic [4:0] OP_BGEZ = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JAL  = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_MUL  = 5'd20;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StMulWait
  } exe_state_e;

endpackage

// File: rtl/exe_if.sv
// Execute-stage bus: upstream valid/ready request side and downstream result side.
interface exe_if #(
  parameter int unsigned WIDTH = exe_pkg::DEF_WIDTH,
  parameter int unsigned PC_W  = WIDTH - 2
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] ir_in;
  logic [PC_W-1:0]  pc_in;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ir_out;
  logic [PC_W-1:0]  pc_out;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] addr;
  logic             br_taken;
  logic [PC_W-1:0]  br_addr;
  logic             op_illegal;
  logic             fc;
  logic             fv;
  logic             fz;
  logic             fn;

  modport master (
    output in_valid, op, ir_in, pc_in, x, y, out_ready,
    input  in_ready, out_valid, ir_out, pc_out, z, addr, br_taken, br_addr, op_illegal,
    input  fc, fv, fz, fn
  );

  modport slave (
    input  in_valid, op, ir_in, pc_in, x, y, out_ready,
    output in_ready, out_valid, ir_out, pc_out, z, addr, br_taken, br_addr, op_illegal,
    output fc, fv, fz, fn
  );
endinterface

// File: rtl/exe_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; p holds after busy drops.
module exe_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= CntW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_q <= 1'b0;
    end
  end

  // done marks the cycle whose edge performs the final iteration
  assign done = busy_q && (cnt_q == CntW'(1));
  assign busy = busy_q;
  assign p    = acc_q;

endmodule

// File: rtl/exe_unit.sv
// MyProc execute stage with valid/ready on both sides and registered flags.
// Optional iterative multiply enabled by defining EXE_MUL_EN.
module exe_unit
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned PC_W  = WIDTH - 2,
  parameter int unsigned SH_W  = $clog2(WIDTH)
) (
  input logic  clk,
  input logic  rst,
  exe_if.slave bus
);

  exe_state_e       state_q;
  logic             out_valid_q, br_taken_q, op_illegal_q;
  logic [WIDTH-1:0] ir_q, z_q, addr_q;
  logic [PC_W-1:0]  pc_q, br_addr_q;
  logic [3:0]       flags_q;

  logic [WIDTH:0]   sum, diff, shl, shr, sra;
  logic [SH_W-1:0]  sh;
  logic [PC_W-1:0]  br_tgt;
  logic             x_neg, x_zero;

  logic [WIDTH-1:0] r_z, r_addr;
  logic [PC_W-1:0]  r_br_addr;
  logic             r_br_taken, r_illegal, upd_zn;
  logic [3:0]       r_flags;

  logic             in_fire, ld_en;
  logic [WIDTH-1:0] ld_ir, ld_z, ld_addr;
  logic [PC_W-1:0]  ld_pc, ld_br_addr;
  logic             ld_br_taken, ld_illegal;
  logic [3:0]       ld_flags;

`ifdef EXE_MUL_EN
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]   mul_ir_q;
  logic [PC_W-1:0]    mul_pc_q;

  assign mul_start = in_fire && (bus.op == OP_MUL);

  exe_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (bus.x),
    .b     (bus.y),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );
`endif

  assign bus.in_ready = !rst && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign sh     = bus.y[SH_W-1:0];
  assign sum    = {1'b0, bus.x} + {1'b0, bus.y};
  assign diff   = {1'b0, bus.x} - {1'b0, bus.y};
  // One guard bit on the shifted-out side captures the last bit lost (0 when sh == 0)
  assign shl    = {1'b0, bus.x} << sh;
  assign shr    = {bus.x, 1'b0} >> sh;
  assign sra    = $signed({bus.x, 1'b0}) >>> sh;
  assign br_tgt = bus.pc_in + (bus.y[PC_W-1:0] << 2);
  assign x_neg  = bus.x[WIDTH-1];
  assign x_zero = (bus.x == '0);

  always_comb begin
    r_z        = '0;
    r_addr     = '0;
    r_br_taken = 1'b0;
    r_br_addr  = '0;
    r_illegal  = 1'b0;
    r_flags    = flags_q;
    upd_zn     = 1'b0;
    case (bus.op)
      OP_ADD: begin
        r_z             = sum[WIDTH-1:0];
        r_flags[FLAG_C] = sum[WIDTH];
        r_flags[FLAG_V] = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum[WIDTH-1] != x_neg);
        upd_zn          = 1'b1;
      end
      OP_SUB: begin
        r_z             = diff[WIDTH-1:0];
        r_flags[FLAG_C] = diff[WIDTH];
        r_flags[FLAG_V] = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (diff[WIDTH-1] != x_neg);
        upd_zn          = 1'b1;
      end
      OP_AND: begin r_z = bus.x & bus.y; upd_zn = 1'b1; end
      OP_OR:  begin r_z = bus.x | bus.y; upd_zn = 1'b1; end
      OP_XOR: begin r_z = bus.x ^ bus.y; upd_zn = 1'b1; end
      OP_SLL: begin r_z = shl[WIDTH-1:0]; r_flags[FLAG_C] = shl[WIDTH]; upd_zn = 1'b1; end
      OP_SRL: begin r_z = shr[WIDTH:1];   r_flags[FLAG_C] = shr[0];     upd_zn = 1'b1; end
      OP_SRA: begin r_z = sra[WIDTH:1];   r_flags[FLAG_C] = sra[0];     upd_zn = 1'b1; end
      OP_LUI: r_z = bus.y << (WIDTH / 2);
      OP_LD:  r_addr = sum[WIDTH-1:0];
      OP_ST:  begin r_addr = sum[WIDTH-1:0]; r_z = bus.x; end
      OP_BEQZ: begin r_br_taken = x_zero;             r_br_addr = br_tgt; end
      OP_BNEZ: begin r_br_taken = !x_zero;            r_br_addr = br_tgt; end
      OP_BGTZ: begin r_br_taken = !x_neg && !x_zero;  r_br_addr = br_tgt; end
      OP_BLTZ: begin r_br_taken = x_neg;              r_br_addr = br_tgt; end
      OP_BLEZ: begin r_br_taken = x_neg || x_zero;    r_br_addr = br_tgt; end
      OP_BGEZ: begin r_br_taken = !x_neg;             r_br_addr = br_tgt; end
      OP_J:    begin r_br_taken = 1'b1; r_br_addr = bus.x[PC_W-1:0]; end
      OP_JR:   begin r_br_taken = 1'b1; r_br_addr = sum[PC_W-1:0]; end
      OP_JAL: begin
        r_br_taken = 1'b1;
        r_br_addr  = bus.x[PC_W-1:0];
        r_z        = WIDTH'(bus.pc_in);
      end
`ifdef EXE_MUL_EN
      OP_MUL:  r_illegal = 1'b0;
`endif
      default: r_illegal = 1'b1;
    endcase
    if (upd_zn) begin
      r_flags[FLAG_Z] = (r_z == '0);
      r_flags[FLAG_N] = r_z[WIDTH-1];
    end
  end

  // Output register source: a single-cycle result, or a finished multiply
  always_comb begin
    ld_en       = 1'b0;
    ld_ir       = bus.ir_in;
    ld_pc       = bus.pc_in;
    ld_z        = r_z;
    ld_addr     = r_addr;
    ld_br_taken = r_br_taken;
    ld_br_addr  = r_br_addr;
    ld_illegal  = r_illegal;
    ld_flags    = r_flags;
    if (state_q == StIdle) begin
`ifdef EXE_MUL_EN
      ld_en = in_fire && (bus.op != OP_MUL);
`else
      ld_en = in_fire;
`endif
    end
`ifdef EXE_MUL_EN
    else if (state_q == StMulWait && (!out_valid_q || bus.out_ready)) begin
      ld_en            = 1'b1;
      ld_ir            = mul_ir_q;
      ld_pc            = mul_pc_q;
      ld_z             = mul_p[WIDTH-1:0];
      ld_addr          = '0;
      ld_br_taken      = 1'b0;
      ld_br_addr       = '0;
      ld_illegal       = 1'b0;
      ld_flags         = flags_q;
      ld_flags[FLAG_V] = |mul_p[2*WIDTH-1:WIDTH];
      ld_flags[FLAG_Z] = (mul_p[WIDTH-1:0] == '0);
      ld_flags[FLAG_N] = mul_p[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      ir_q         <= '0;
      pc_q         <= '0;
      z_q          <= '0;
      addr_q       <= '0;
      br_taken_q   <= 1'b0;
      br_addr_q    <= '0;
      op_illegal_q <= 1'b0;
      flags_q      <= '0;
`ifdef EXE_MUL_EN
      mul_ir_q     <= '0;
      mul_pc_q     <= '0;
`endif
    end else begin
      if (ld_en) begin
        out_valid_q  <= 1'b1;
        ir_q         <= ld_ir;
        pc_q         <= ld_pc;
        z_q          <= ld_z;
        addr_q       <= ld_addr;
        br_taken_q   <= ld_br_taken;
        br_addr_q    <= ld_br_addr;
        op_illegal_q <= ld_illegal;
        flags_q      <= ld_flags;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
`ifdef EXE_MUL_EN
          if (mul_start) begin
            state_q  <= StMulRun;
            mul_ir_q <= bus.ir_in;
            mul_pc_q <= bus.pc_in;
          end
`endif
        end
`ifdef EXE_MUL_EN
        StMulRun:  if (mul_done || !mul_busy) state_q <= StMulWait;
        StMulWait: if (ld_en) state_q <= StIdle;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.ir_out     = ir_q;
  assign bus.pc_out     = pc_q;
  assign bus.z          = z_q;
  assign bus.addr       = addr_q;
  assign bus.br_taken   = br_taken_q;
  assign bus.br_addr    = br_addr_q;
  assign bus.op_illegal = op_illegal_q;
  assign bus.fc         = flags_q[FLAG_C];
  assign bus.fv         = flags_q[FLAG_V];
  assign bus.fz         = flags_q[FLAG_Z];
  assign bus.fn         = flags_q[FLAG_N];

endmodule

// File: tb/tb_exe_unit.sv
// Directed bench for exe_unit (WIDTH=32); MUL checks follow EXE_MUL_EN.
module tb_exe_unit;
  import exe_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 30;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   lat;

  exe_if #(.WIDTH(W), .PC_W(PW)) bus ();

  exe_unit #(
    .WIDTH (W),
    .PC_W  (PW),
    .SH_W  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [29:0] pc);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.x        = x;
    bus.y        = y;
    bus.pc_in    = pc;
    bus.ir_in    = 32'hA500_0000 | {27'h0, op};
  endtask

  function automatic logic [3:0] flags();
    return {bus.fc, bus.fv, bus.fz, bus.fn};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = OP_ADD;
    bus.x = '0;
    bus.y = '0;
    bus.pc_in = '0;
    bus.ir_in = '0;
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_flags", flags(), 4'b0000);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    // Flags listed as {fc, fv, fz, fn}
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 30'd40);
    step();
    chk("add_valid", bus.out_valid, 1);
    chk("add_z", bus.z, 32'h8000_0000);
    chk("add_flags", flags(), 4'b0101);
    chk("add_ir", bus.ir_out, 32'hA500_0000);
    chk("add_pc", bus.pc_out, 40);
    chk("add_br", bus.br_taken, 0);

    drive(OP_SUB, 32'd5, 32'd5, 30'd0);
    step();
    chk("sub_z", bus.z, 0);
    chk("sub_flags", flags(), 4'b0010);

    drive(OP_SUB, 32'd0, 32'd1, 30'd0);
    step();
    chk("sub_borrow_z", bus.z, 32'hFFFF_FFFF);
    chk("sub_borrow_flags", flags(), 4'b1001);

    drive(OP_AND, 32'hF0, 32'h0F, 30'd0);
    step();
    chk("and_z", bus.z, 0);
    chk("and_flags_c_held", flags(), 4'b1010);

    drive(OP_SRA, 32'h8000_0010, 32'd4, 30'd0);
    step();
    chk("sra_z", bus.z, 32'hF800_0001);
    chk("sra_flags", flags(), 4'b0001);

    drive(OP_SLL, 32'd1, 32'd31, 30'd0);
    step();
    chk("sll_z", bus.z, 32'h8000_0000);
    chk("sll_flags", flags(), 4'b0001);

    drive(OP_SRL, 32'd3, 32'd1, 30'd0);
    step();
    chk("srl_z", bus.z, 32'h1);
    chk("srl_flags", flags(), 4'b1000);

    drive(OP_BLTZ, 32'hFFFF_FFFF, 32'd3, 30'd100);
    step();
    chk("bltz_taken", bus.br_taken, 1);
    chk("bltz_addr", bus.br_addr, 112);
    chk("bltz_flags_held", flags(), 4'b1000);

    drive(OP_BGTZ, 32'd0, 32'd1, 30'd200);
    step();
    chk("bgtz_zero_taken", bus.br_taken, 0);

    drive(OP_JAL, 32'h400, 32'd0, 30'h55);
    step();
    chk("jal_taken", bus.br_taken, 1);
    chk("jal_addr", bus.br_addr, 32'h400);
    chk("jal_link", bus.z, 32'h55);

    drive(OP_LD, 32'h1000, 32'hFFFF_FFFC, 30'd0);
    step();
    chk("ld_addr", bus.addr, 32'hFFC);
    chk("ld_br", bus.br_taken, 0);

    drive(OP_ST, 32'hABCD, 32'd8, 30'd0);
    step();
    chk("st_addr", bus.addr, 32'hABD5);
    chk("st_data", bus.z, 32'hABCD);

    drive(OP_LUI, 32'd0, 32'h1234, 30'd0);
    step();
    chk("lui_z", bus.z, 32'h1234_0000);

    drive(5'd31, 32'h1, 32'h1, 30'd7);
    step();
    chk("ill_flag", bus.op_illegal, 1);
    chk("ill_z", bus.z, 0);
    chk("ill_pc", bus.pc_out, 7);
    chk("ill_flags_held", flags(), 4'b1000);

    // Output stall: result must hold while the next instruction waits
    drive(OP_ADD, 32'd2, 32'd3, 30'd0);
    step();
    chk("stall_add_z", bus.z, 5);
    bus.out_ready = 1'b0;
    drive(OP_OR, 32'hF0, 32'h0F, 30'd0);
    #1;
    chk("stall_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_z", bus.z, 5);
      chk("stall_in_ready_hold", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    step();
    chk("or_z", bus.z, 32'hFF);
    chk("or_flags", flags(), 4'b0000);

`ifdef EXE_MUL_EN
    drive(OP_MUL, 32'h1_0000, 32'h1_0000, 30'd9);
    step();
    bus.in_valid = 1'b0;
    chk("mul_drained", bus.out_valid, 0);
    chk("mul_in_ready", bus.in_ready, 0);
    lat = 1;
    while (lat < 3 * W) begin
      step();
      if (bus.out_valid) break;
      lat++;
    end
    chk("mul_latency", lat, W + 1);
    chk("mul_z", bus.z, 0);
    chk("mul_flags", flags(), 4'b0110);
    chk("mul_pc", bus.pc_out, 9);

    drive(OP_MUL, 32'd3, 32'd5, 30'd0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mulrst_valid", bus.out_valid, 0);
    chk("mulrst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < W + 4; i++) step();
    chk("mulrst_discard", bus.out_valid, 0);
`else
    drive(OP_MUL, 32'h1_0000, 32'h1_0000, 30'd9);
    step();
    bus.in_valid = 1'b0;
    chk("mul_off_valid", bus.out_valid, 1);
    chk("mul_off_illegal", bus.op_illegal, 1);
    chk("mul_off_z", bus.z, 0);
    chk("mul_off_flags", flags(), 4'b0000);
`endif

    drive(OP_XOR, 32'hFFFF_0000, 32'h0000_FFFF, 30'd0);
    step();
    bus.in_valid = 1'b0;
    chk("xor_z", bus.z, 32'hFFFF_FFFF);
    chk("xor_illegal", bus.op_illegal, 0);
    step();
    chk("final_drained", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
